// File: rtl/dr_tx_bridge.sv
// dr_tx_bridge: clocked valid/ready words to 4-phase return-to-zero dual-rail tokens.
// Owns the DIMS initialize line (PI) and completes each token on the receiver's ACK.
module dr_tx_bridge #(
  parameter int WIDTH       = 8,
  parameter int INIT_CYCLES = 4,
  parameter int TIMEOUT     = 255,
  parameter int CNT_W       = 16
) (
  input  logic             CK,
  input  logic             RST,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic [WIDTH-1:0] D_f,
  output logic [WIDTH-1:0] D_t,
  input  logic             ACK,
  output logic             PI,
  output logic             err,
  input  logic             err_clr,
  output logic [CNT_W-1:0] tok_cnt
);

  // state  | meaning
  // S_INIT | PI high, rails spacer, held for INIT_CYCLES cycles
  // S_IDLE | rails spacer, waiting for a word (and for ack_s low)
  // S_DATA | codeword on rails, waiting for ack_s to rise
  // S_NULL | spacer on rails, waiting for ack_s to fall
  typedef enum logic [1:0] {S_INIT, S_IDLE, S_DATA, S_NULL} state_t;

  localparam int T_MAX = (TIMEOUT > INIT_CYCLES) ? TIMEOUT : INIT_CYCLES;
  localparam int TW    = $clog2(T_MAX + 1);
  localparam logic [TW-1:0] INIT_LAST = TW'(INIT_CYCLES - 1);
  localparam logic [TW-1:0] TO_LAST   = TW'(TIMEOUT - 1);

  state_t        state;
  logic [TW-1:0] timer;
  logic          ack_meta;
  logic          ack_s;
  logic          timeout;

  assign in_ready = (state == S_IDLE) && !ack_s;

  // Fires on the edge that would otherwise be the TIMEOUT-th waiting cycle.
  assign timeout = ((state == S_DATA && !ack_s) || (state == S_NULL && ack_s)) &&
                   (timer == TO_LAST);

  always_ff @(posedge CK) begin
    if (RST) begin
      state    <= S_INIT;
      timer    <= '0;
      ack_meta <= 1'b0;
      ack_s    <= 1'b0;
      D_f      <= '0;
      D_t      <= '0;
      PI       <= 1'b1;
      err      <= 1'b0;
      tok_cnt  <= '0;
    end else begin
      ack_meta <= ACK;
      ack_s    <= ack_meta;

      if (timeout)
        err <= 1'b1;
      else if (err_clr)
        err <= 1'b0;

      case (state)
        S_INIT: begin
          if (timer == INIT_LAST) begin
            state <= S_IDLE;
            PI    <= 1'b0;
            timer <= '0;
          end else begin
            timer <= timer + TW'(1);
          end
        end
        S_IDLE: begin
          if (in_valid && in_ready) begin
            D_t   <= in_data;
            D_f   <= ~in_data;
            timer <= '0;
            state <= S_DATA;
          end
        end
        S_DATA: begin
          if (ack_s) begin
            D_t   <= '0;
            D_f   <= '0;
            timer <= '0;
            state <= S_NULL;
          end else if (timeout) begin
            D_t   <= '0;
            D_f   <= '0;
            PI    <= 1'b1;
            timer <= '0;
            state <= S_INIT;
          end else begin
            timer <= timer + TW'(1);
          end
        end
        S_NULL: begin
          if (!ack_s) begin
            tok_cnt <= tok_cnt + CNT_W'(1);
            timer   <= '0;
            state   <= S_IDLE;
          end else if (timeout) begin
            PI    <= 1'b1;
            timer <= '0;
            state <= S_INIT;
          end else begin
            timer <= timer + TW'(1);
          end
        end
        default: begin
          D_t   <= '0;
          D_f   <= '0;
          PI    <= 1'b1;
          timer <= '0;
          state <= S_INIT;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dr_tx_bridge.sv
// Bench for dr_tx_bridge: directed steps plus random tokens against a cycle model of the
// 2-flop-synchronized 4-phase handshake; a second instance with a 3-bit counter shows wrap.
module tb_dr_tx_bridge;
  localparam int W = 8;

  logic          CK = 1'b0;
  logic          RST, in_valid, ACK, err_clr;
  logic [W-1:0]  in_data;
  logic          in_ready, PI, err;
  logic [W-1:0]  D_f, D_t;
  logic [15:0]   tok_cnt;
  logic          in_ready2, PI2, err2;
  logic [W-1:0]  D_f2, D_t2;
  logic [2:0]    tok_cnt2;

  int total = 0;
  int bad = 0;
  int ack_mode = 1;   // 0: auto responder, 1: hold low, 2: hold high
  int ack_lat = 3;
  int exp_tok = 0;

  always #5 CK = ~CK;

  dr_tx_bridge #(.WIDTH(W), .INIT_CYCLES(4), .TIMEOUT(255), .CNT_W(16)) dut (
    .CK(CK), .RST(RST), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .D_f(D_f), .D_t(D_t), .ACK(ACK), .PI(PI), .err(err), .err_clr(err_clr),
    .tok_cnt(tok_cnt));

  dr_tx_bridge #(.WIDTH(W), .INIT_CYCLES(4), .TIMEOUT(255), .CNT_W(3)) dut2 (
    .CK(CK), .RST(RST), .in_valid(in_valid), .in_ready(in_ready2), .in_data(in_data),
    .D_f(D_f2), .D_t(D_t2), .ACK(ACK), .PI(PI2), .err(err2), .err_clr(err_clr),
    .tok_cnt(tok_cnt2));

  // Receiver model: toggles ACK once the rails have shown a complete codeword or
  // a full spacer for ack_lat consecutive samples.
  initial begin
    int cnt;
    logic want;
    cnt = 0;
    ACK = 1'b0;
    forever begin
      @(posedge CK);
      #2;
      if (ack_mode == 1) begin
        ACK = 1'b0; cnt = 0;
      end else if (ack_mode == 2) begin
        ACK = 1'b1; cnt = 0;
      end else begin
        if ((D_f | D_t) == {W{1'b1}})  want = 1'b1;
        else if ((D_f | D_t) == '0)    want = 1'b0;
        else                           want = ACK;
        if (want != ACK) begin
          cnt++;
          if (cnt >= ack_lat) begin ACK = want; cnt = 0; end
        end else begin
          cnt = 0;
        end
      end
    end
  end

  initial begin
    forever begin
      @(negedge CK);
      total++;
      assert (((D_f & D_t) | (D_f2 & D_t2)) === '0)
      else begin
        bad++;
        $error("FAIL rail_excl obs=%h/%h exp=0", D_f & D_t, D_f2 & D_t2);
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    int p;
    RST = 1'b1;
    @(negedge CK);
    @(negedge CK);
    chk("rst_pi", PI, 1);
    chk("rst_pi2", PI2, 1);
    chk("rst_rails", D_t | D_f, 0);
    chk("rst_rdy", in_ready, 0);
    chk("rst_err", err, 0);
    chk("rst_tok", tok_cnt, 0);
    chk("rst_tok2", tok_cnt2, 0);
    RST = 1'b0;
    exp_tok = 0;
    p = 1;
    @(negedge CK);
    while (PI === 1'b1 && p < 50) begin
      chk("init_rails", D_t | D_f, 0);
      chk("init_rdy", in_ready, 0);
      p++;
      @(negedge CK);
    end
    chk("init_len", p, 4);
    chk("idle_rdy", in_ready, 1);
  endtask

  // Token with the receiver responding after lat samples: codeword visible lat+2
  // cycles, spacer lat+2 cycles (two synchronizer flops each way).
  task automatic send(input logic [W-1:0] word, input int lat, input bit hold);
    int w, dcyc, ncyc;
    logic [W-1:0] nword;
    nword = ~word;
    ack_mode = 0;
    ack_lat = lat;
    in_valid = 1'b1;
    in_data = word;
    w = 0;
    while (in_ready !== 1'b1 && w < 100) begin @(negedge CK); w++; end
    chk("accept_wait", w < 100, 1);
    if (w >= 100) begin in_valid = 1'b0; return; end
    @(negedge CK);
    in_valid = hold;
    exp_tok++;
    dcyc = 0;
    while ((D_t | D_f) !== '0 && dcyc < 400) begin
      chk("data_t", D_t, word);
      chk("data_f", D_f, nword);
      chk("data_rdy", in_ready, 0);
      in_data = W'($urandom);
      dcyc++;
      @(negedge CK);
    end
    ncyc = 0;
    while (in_ready !== 1'b1 && ncyc < 400) begin
      chk("null_rails", D_t | D_f, 0);
      ncyc++;
      @(negedge CK);
    end
    chk("data_cycles", dcyc, lat + 2);
    chk("null_cycles", ncyc, lat + 2);
    chk("tok_cnt", tok_cnt, exp_tok[15:0]);
    chk("tok_cnt_w3", tok_cnt2, exp_tok % 8);
    chk("tok_err", err, 0);
    if (!hold) in_valid = 1'b0;
  endtask

  task automatic run_timeout(input logic [W-1:0] word, input bit clr_held);
    int w, c, p;
    ack_mode = 1;
    err_clr = clr_held;
    in_valid = 1'b1;
    in_data = word;
    w = 0;
    while (in_ready !== 1'b1 && w < 100) begin @(negedge CK); w++; end
    chk("to_accept_wait", w < 100, 1);
    @(negedge CK);
    in_valid = 1'b0;
    c = 0;
    while (err !== 1'b1 && c < 400) begin
      chk("to_rails", D_t, word);
      c++;
      @(negedge CK);
    end
    chk("to_cycles", c, 255);
    chk("to_err_set", err, 1);
    chk("to_rails0", D_t | D_f, 0);
    chk("to_tok", tok_cnt, exp_tok[15:0]);
    p = 0;
    while (PI === 1'b1 && p < 50) begin p++; @(negedge CK); end
    chk("to_init_len", p, 4);
    chk("to_rdy", in_ready, 1);
    chk("to_err_after", err, clr_held ? 0 : 1);
    err_clr = 1'b1;
    @(negedge CK);
    err_clr = 1'b0;
    chk("err_clr", err, 0);
  endtask

  initial begin
    int c, hi;
    RST = 1'b1;
    in_valid = 1'b0;
    in_data = '0;
    err_clr = 1'b0;

    do_reset();

    send(8'hA5, 3, 1'b0);

    send(8'h00, 3, 1'b1);
    send(8'hFF, 3, 1'b1);
    send(8'h3C, 3, 1'b0);
    chk("b2b_tok", tok_cnt, 4);

    run_timeout(8'h96, 1'b0);
    run_timeout(8'h69, 1'b1);

    // ACK stuck high while idle
    ack_mode = 2;
    repeat (3) @(negedge CK);
    in_valid = 1'b1;
    in_data = 8'h11;
    hi = 0;
    repeat (300) begin
      if (in_ready !== 1'b0) hi++;
      if ((D_t | D_f) !== '0) hi++;
      @(negedge CK);
    end
    in_valid = 1'b0;
    chk("stuck_rdy", hi, 0);
    chk("stuck_err", err, 0);
    ack_mode = 1;
    c = 0;
    while (in_ready !== 1'b1 && c < 20) begin @(negedge CK); c++; end
    chk("release_rdy", c, 3);

    // reset in the middle of a token
    ack_mode = 1;
    in_valid = 1'b1;
    in_data = 8'hA5;
    c = 0;
    while (in_ready !== 1'b1 && c < 100) begin @(negedge CK); c++; end
    @(negedge CK);
    in_valid = 1'b0;
    chk("mid_rails", D_t, 8'hA5);
    RST = 1'b1;
    @(negedge CK);
    chk("mid_rst_rails", D_t | D_f, 0);
    chk("mid_rst_pi", PI, 1);
    chk("mid_rst_tok", tok_cnt, 0);
    do_reset();

    for (int i = 0; i < 12; i++)
      send(W'($urandom), int'($urandom_range(1, 4)), i[0]);
    in_valid = 1'b0;
    chk("wrap_tok2", tok_cnt2, 4);
    chk("final_tok", tok_cnt, 12);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
